// File: rtl/reg_control_d.sv
// Decode-stage pipeline register with load-use hazard detection.
// Holds fetch and D for two cycles when the D instruction consumes a load still in E.
module reg_control_d #(
    parameter int unsigned PC_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            jump_reset,
    input  logic [PC_W-1:0] pc_in,
    input  logic [31:0]     inst_in,
    input  logic [31:0]     inst_E,
    output logic [PC_W-1:0] pc_out,
    output logic [31:0]     inst_out,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    output logic [4:0]      rd_addr,
    output logic [31:0]     imm,
    output logic            E_stop,
    output logic            pc_stall
);

    localparam int unsigned OP_W = 7;

    localparam logic [OP_W-1:0] OP_LUI   = 7'b0110111;
    localparam logic [OP_W-1:0] OP_AUIPC = 7'b0010111;
    localparam logic [OP_W-1:0] OP_JAL   = 7'b1101111;
    localparam logic [OP_W-1:0] OP_JALR  = 7'b1100111;
    localparam logic [OP_W-1:0] OP_B     = 7'b1100011;
    localparam logic [OP_W-1:0] OP_L     = 7'b0000011;
    localparam logic [OP_W-1:0] OP_S     = 7'b0100011;
    localparam logic [OP_W-1:0] OP_IALU  = 7'b0010011;
    localparam logic [OP_W-1:0] OP_AR    = 7'b0110011;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [31:0]       inst_q, inst_d;

    logic [OP_W-1:0]   op_d_c;
    logic [OP_W-1:0]   op_e_c;
    logic [4:0]        rd_e_c;
    logic              uses_rs1_c;
    logic              uses_rs2_c;
    logic              hazard_c;
    logic              stop_c;
    logic [19:0]       unused_inst_e;

    assign op_d_c        = inst_q[6:0];
    assign op_e_c        = inst_E[6:0];
    assign rd_e_c        = inst_E[11:7];
    assign unused_inst_e = inst_E[31:12];

    // Source-register usage of the D instruction
    always_comb begin
        uses_rs1_c = 1'b0;
        uses_rs2_c = 1'b0;
        case (op_d_c)
            OP_JALR, OP_L, OP_IALU: uses_rs1_c = 1'b1;
            OP_B, OP_S, OP_AR: begin
                uses_rs1_c = 1'b1;
                uses_rs2_c = 1'b1;
            end
            default: ;
        endcase
    end

    assign hazard_c = (op_e_c == OP_L) && (rd_e_c != 5'd0) &&
                      ((uses_rs1_c && (inst_q[19:15] == rd_e_c)) ||
                       (uses_rs2_c && (inst_q[24:20] == rd_e_c)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            pc_q    <= '0;
            inst_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
        end
    end

    // Next state and stall outputs; a taken jump overrides any stall
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        stop_c  = 1'b0;
        if (jump_reset) begin
            state_d = RUN;
            pc_d    = '0;
            inst_d  = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (hazard_c) begin
                        stop_c  = 1'b1;
                        state_d = HOLD;
                    end else begin
                        pc_d   = pc_in;
                        inst_d = inst_in;
                    end
                end
                HOLD: begin
                    stop_c  = 1'b1;
                    state_d = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    // Immediate generation from the held D instruction
    always_comb begin
        imm = 32'd0;
        case (op_d_c)
            OP_L, OP_JALR, OP_IALU:
                imm = {{20{inst_q[31]}}, inst_q[31:20]};
            OP_S:
                imm = {{20{inst_q[31]}}, inst_q[31:25], inst_q[11:7]};
            OP_B:
                imm = {{19{inst_q[31]}}, inst_q[31], inst_q[7], inst_q[30:25],
                       inst_q[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm = {inst_q[31:12], 12'd0};
            OP_JAL:
                imm = {{11{inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20],
                       inst_q[30:21], 1'b0};
            default: imm = 32'd0;
        endcase
    end

    assign pc_out   = pc_q;
    assign inst_out = inst_q;
    assign rs1_addr = inst_q[19:15];
    assign rs2_addr = inst_q[24:20];
    assign rd_addr  = inst_q[11:7];
    assign E_stop   = stop_c;
    assign pc_stall = stop_c;

endmodule
